// File: rtl/vga_text_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_ctrl_pkg
// Description : Shared timing defaults, colours and pipeline types for the
//               80x30 text-mode VGA controller.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_text_ctrl_pkg;

    localparam logic [9:0] C_H_ACTIVE = 10'd640;
    localparam logic [9:0] C_H_FP     = 10'd16;
    localparam logic [9:0] C_H_SYNC   = 10'd96;
    localparam logic [9:0] C_H_BP     = 10'd48;
    localparam logic [9:0] C_V_ACTIVE = 10'd480;
    localparam logic [9:0] C_V_FP     = 10'd10;
    localparam logic [9:0] C_V_SYNC   = 10'd2;
    localparam logic [9:0] C_V_BP     = 10'd33;

    localparam logic [2:0] C_FG_RGB   = 3'b010;
    localparam logic [2:0] C_BG_RGB   = 3'b000;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       active;
        logic [2:0] px;
    } pix_tag_t;

    typedef struct packed {
        pix_tag_t   tag;
        logic [3:0] line;
    } fetch_meta_t;

    localparam pix_tag_t    C_TAG_IDLE  = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0, px: 3'd0};
    localparam fetch_meta_t C_META_IDLE = '{tag: C_TAG_IDLE, line: 4'd0};

    // row*80 + col without a multiplier: row*64 + row*16 + col
    function automatic logic [11:0] char_addr(input logic [5:0] row, input logic [6:0] col);
        return {row, 6'd0} + {2'd0, row, 4'd0} + {5'd0, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_text_ctrl_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_ctrl_timing
// Description : Horizontal/vertical scan counters with raw sync, active-area
//               and vblank-start strobe, all advancing on the pixel enable.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_text_ctrl_timing
    import vga_text_ctrl_pkg::*;
#(
    parameter logic [9:0] H_ACTIVE = C_H_ACTIVE,
    parameter logic [9:0] H_FP     = C_H_FP,
    parameter logic [9:0] H_SYNC   = C_H_SYNC,
    parameter logic [9:0] H_BP     = C_H_BP,
    parameter logic [9:0] V_ACTIVE = C_V_ACTIVE,
    parameter logic [9:0] V_FP     = C_V_FP,
    parameter logic [9:0] V_SYNC   = C_V_SYNC,
    parameter logic [9:0] V_BP     = C_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_ce_i,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       active_o,
    output logic       vblank_start_o
);

    localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] HS_START = H_ACTIVE + H_FP;
    localparam logic [9:0] HS_END   = HS_START + H_SYNC;
    localparam logic [9:0] VS_START = V_ACTIVE + V_FP;
    localparam logic [9:0] VS_END   = VS_START + V_SYNC;

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_ce_i) begin
            if (h_cnt_q == H_TOTAL - 10'd1) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_TOTAL - 10'd1) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    assign h_cnt_o        = h_cnt_q;
    assign v_cnt_o        = v_cnt_q;
    assign hsync_o        = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    assign vsync_o        = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    assign active_o       = (h_cnt_q < H_ACTIVE) && (v_cnt_q < V_ACTIVE);
    assign vblank_start_o = pix_ce_i && (h_cnt_q == 10'd0) && (v_cnt_q == V_ACTIVE);

endmodule
`default_nettype wire

// File: rtl/vga_text_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_ctrl
// Description : 80x30 text-mode VGA controller: char fetch from video RAM,
//               glyph fetch from font ROM, 1bpp shift-out and vblank flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_text_ctrl
    import vga_text_ctrl_pkg::*;
#(
    parameter logic [9:0] H_ACTIVE = C_H_ACTIVE,
    parameter logic [9:0] H_FP     = C_H_FP,
    parameter logic [9:0] H_SYNC   = C_H_SYNC,
    parameter logic [9:0] H_BP     = C_H_BP,
    parameter logic [9:0] V_ACTIVE = C_V_ACTIVE,
    parameter logic [9:0] V_FP     = C_V_FP,
    parameter logic [9:0] V_SYNC   = C_V_SYNC,
    parameter logic [9:0] V_BP     = C_V_BP,
    parameter logic [2:0] FG_RGB   = C_FG_RGB,
    parameter logic [2:0] BG_RGB   = C_BG_RGB
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_ce,
    output logic [11:0] vmem_r_addr,
    output logic        vmem_r_en,
    input  logic [7:0]  vmem_dout,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_dout,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  rgb,
    output logic        vblank_flag,
    input  logic        vblank_flag_clr
);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hsync_raw;
    logic       vsync_raw;
    logic       active;
    logic       vblank_start;

    vga_text_ctrl_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk            (clk),
        .rst_n          (rst_n),
        .pix_ce_i       (pix_ce),
        .h_cnt_o        (h_cnt),
        .v_cnt_o        (v_cnt),
        .hsync_o        (hsync_raw),
        .vsync_o        (vsync_raw),
        .active_o       (active),
        .vblank_start_o (vblank_start)
    );

    logic [11:0] addr_calc;
    logic [11:0] addr_hold_q, addr_hold_d;
    fetch_meta_t s1_q, s1_d;
    pix_tag_t    s2_q;
    logic [2:0]  rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        flag_q, flag_d;
    logic        glyph_bit;
    logic        unused_char_msb;

    assign addr_calc       = char_addr(v_cnt[9:4], h_cnt[9:3]);
    assign unused_char_msb = vmem_dout[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold_q <= 12'd0;
            s1_q        <= C_META_IDLE;
            s2_q        <= C_TAG_IDLE;
            rgb_q       <= 3'b000;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            flag_q      <= 1'b0;
        end else begin
            addr_hold_q <= addr_hold_d;
            s1_q        <= s1_d;
            // Tracks the font ROM's fixed 1-clk latency rather than pix_ce, so the
            // tag always pairs with the glyph row currently on font_dout.
            s2_q        <= s1_q.tag;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            flag_q      <= flag_d;
        end
    end

    always_comb begin
        addr_hold_d = addr_hold_q;
        s1_d        = s1_q;
        rgb_d       = rgb_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        glyph_bit   = font_dout[3'd7 - s2_q.px];
        if (pix_ce) begin
            if (active) begin
                addr_hold_d = addr_calc;
            end
            s1_d.tag.hsync  = hsync_raw;
            s1_d.tag.vsync  = vsync_raw;
            s1_d.tag.active = active;
            s1_d.tag.px     = h_cnt[2:0];
            s1_d.line       = v_cnt[3:0];
            hsync_d         = s2_q.hsync;
            vsync_d         = s2_q.vsync;
            rgb_d           = s2_q.active ? (glyph_bit ? FG_RGB : BG_RGB) : 3'b000;
        end
        // Set wins over a simultaneous clear so no frame interrupt is lost.
        flag_d = vblank_start | (flag_q & ~vblank_flag_clr);
    end

    assign vmem_r_addr = active ? addr_calc : addr_hold_q;
    assign vmem_r_en   = pix_ce & active & rst_n;
    assign font_addr   = {vmem_dout[6:0], s1_q.line};
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign vblank_flag = flag_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_text_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_text_ctrl
// Description : Directed self-checking bench for vga_text_ctrl (short frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_text_ctrl;

    // Short frame: 32 active lines (2 text rows), 36 lines total.
    localparam logic [9:0] TB_V_ACTIVE = 10'd32;
    localparam logic [9:0] TB_V_FP     = 10'd1;
    localparam logic [9:0] TB_V_SYNC   = 10'd2;
    localparam logic [9:0] TB_V_BP     = 10'd1;
    localparam logic [2:0] FG          = 3'b010;
    localparam logic [2:0] BG          = 3'b000;

    logic        clk             = 1'b0;
    logic        rst_n           = 1'b0;
    logic        pix_ce          = 1'b0;
    logic        vblank_flag_clr = 1'b0;
    logic [11:0] vmem_r_addr;
    logic        vmem_r_en;
    logic [7:0]  vmem_dout       = 8'h00;
    logic [10:0] font_addr;
    logic [7:0]  font_dout       = 8'h00;
    logic        hsync;
    logic        vsync;
    logic [2:0]  rgb;
    logic        vblank_flag;

    logic [7:0] vram [0:2399];
    logic [7:0] font [0:2047];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic       stall  = 1'b0;

    vga_text_ctrl #(
        .V_ACTIVE (TB_V_ACTIVE),
        .V_FP     (TB_V_FP),
        .V_SYNC   (TB_V_SYNC),
        .V_BP     (TB_V_BP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix_ce          (pix_ce),
        .vmem_r_addr     (vmem_r_addr),
        .vmem_r_en       (vmem_r_en),
        .vmem_dout       (vmem_dout),
        .font_addr       (font_addr),
        .font_dout       (font_dout),
        .hsync           (hsync),
        .vsync           (vsync),
        .rgb             (rgb),
        .vblank_flag     (vblank_flag),
        .vblank_flag_clr (vblank_flag_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vmem_r_en) vmem_dout <= vram[vmem_r_addr];
        font_dout <= font[font_addr];
    end

    // Sample point is 1 time unit after the edge; inputs set here apply to the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc    = cyc + 1;
        pix_ce = stall ? (cyc % 2 == 0) : 1'b1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_reset(input logic stall_mode);
        rst_n           = 1'b0;
        vblank_flag_clr = 1'b0;
        stall           = stall_mode;
        pix_ce          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        run_to(700);
        checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL pre_reset_hsync: got %b expected %b", hsync, 1'b0); end
        rst_n = 1'b0;
        #1;
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected %b", hsync, 1'b1); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected %b", vsync, 1'b1); end
        checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL reset_rgb: got %h expected %h", rgb, 3'b000); end
        checks++; if (vblank_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b expected %b", vblank_flag, 1'b0); end
        checks++; if (vmem_r_en !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b expected %b", vmem_r_en, 1'b0); end
        @(posedge clk);
        #1;
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hold_hsync: got %b expected %b", hsync, 1'b1); end
        checks++; if (vmem_r_addr !== 12'd0) begin errors++; $display("FAIL reset_addr: got %0d expected %0d", vmem_r_addr, 0); end
    endtask

    task automatic test_render();
        logic [2:0] exp0 [16];
        logic [2:0] exp1 [8];
        exp0 = '{FG, FG, BG, BG, BG, BG, FG, FG,    // 0x41 row0 = C3
                 BG, FG, BG, FG, FG, BG, FG, BG};   // 0x81 -> 0x01 row0 = 5A
        exp1 = '{BG, BG, BG, FG, FG, BG, BG, BG};   // 0x41 row1 = 18
        do_reset(1'b0);
        for (int k = 0; k < 16; k++) begin
            run_to(3 + k);
            checks++; if (rgb !== exp0[k]) begin errors++; $display("FAIL render_l0_px%0d: got %h expected %h", k, rgb, exp0[k]); end
        end
        for (int k = 0; k < 8; k++) begin
            run_to(803 + k);
            checks++; if (rgb !== exp1[k]) begin errors++; $display("FAIL render_l1_px%0d: got %h expected %h", k, rgb, exp1[k]); end
        end
    endtask

    // Continues the run from test_render: h=632,v=16 is cycle 16*800+632.
    task automatic test_address();
        run_to(13432);
        checks++; if (vmem_r_addr !== 12'd159) begin errors++; $display("FAIL addr_last_col: got %0d expected %0d", vmem_r_addr, 159); end
        checks++; if (vmem_r_en !== 1'b1) begin errors++; $display("FAIL ren_active: got %b expected %b", vmem_r_en, 1'b1); end
        run_to(13440);
        checks++; if (vmem_r_en !== 1'b0) begin errors++; $display("FAIL ren_blank: got %b expected %b", vmem_r_en, 1'b0); end
        checks++; if (vmem_r_addr !== 12'd159) begin errors++; $display("FAIL addr_held: got %0d expected %0d", vmem_r_addr, 159); end
        run_to(13442);
        checks++; if (rgb !== FG) begin errors++; $display("FAIL px639: got %h expected %h", rgb, FG); end
        run_to(13443);
        checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL px640_blank: got %h expected %h", rgb, 3'b000); end
    endtask

    // Counters reach (0,32) at cycle 25600.
    task automatic test_vblank_flag();
        run_to(25600);
        checks++; if (vblank_flag !== 1'b0) begin errors++; $display("FAIL flag_before: got %b expected %b", vblank_flag, 1'b0); end
        vblank_flag_clr = 1'b1;
        tick();
        checks++; if (vblank_flag !== 1'b1) begin errors++; $display("FAIL flag_set_wins: got %b expected %b", vblank_flag, 1'b1); end
        vblank_flag_clr = 1'b0;
        tick();
        checks++; if (vblank_flag !== 1'b1) begin errors++; $display("FAIL flag_sticky: got %b expected %b", vblank_flag, 1'b1); end
        vblank_flag_clr = 1'b1;
        tick();
        checks++; if (vblank_flag !== 1'b0) begin errors++; $display("FAIL flag_clr: got %b expected %b", vblank_flag, 1'b0); end
        vblank_flag_clr = 1'b0;
        tick();
        checks++; if (vblank_flag !== 1'b0) begin errors++; $display("FAIL flag_stays_clr: got %b expected %b", vblank_flag, 1'b0); end
    endtask

    task automatic test_timing();
        int hs_low = 0;
        int vs_low = 0;
        int hs_first = -1;
        int vs_first = -1;
        run_to(26000);
        repeat (2400) begin
            tick();
            if (hsync === 1'b0) begin hs_low++; if (hs_first < 0) hs_first = cyc; end
            if (vsync === 1'b0) begin vs_low++; if (vs_first < 0) vs_first = cyc; end
        end
        checks++; if (hs_low != 288) begin errors++; $display("FAIL hsync_low_count: got %0d expected %0d", hs_low, 288); end
        checks++; if (hs_first != 26259) begin errors++; $display("FAIL hsync_first_low: got %0d expected %0d", hs_first, 26259); end
        checks++; if (vs_low != 1600) begin errors++; $display("FAIL vsync_low_count: got %0d expected %0d", vs_low, 1600); end
        checks++; if (vs_first != 26403) begin errors++; $display("FAIL vsync_first_low: got %0d expected %0d", vs_first, 26403); end
    endtask

    task automatic test_stall();
        logic [2:0] exp0 [16];
        logic       prev = 1'b1;
        int         fall0 = -1;
        int         fall1 = -1;
        exp0 = '{FG, FG, BG, BG, BG, BG, FG, FG,
                 BG, FG, BG, FG, FG, BG, FG, BG};
        do_reset(1'b1);
        for (int i = 0; i < 16; i++) begin
            run_to(2 * i + 3);
            checks++; if (rgb !== exp0[i]) begin errors++; $display("FAIL stall_px%0d: got %h expected %h", i, rgb, exp0[i]); end
            run_to(2 * i + 4);
            checks++; if (rgb !== exp0[i]) begin errors++; $display("FAIL stall_hold_px%0d: got %h expected %h", i, rgb, exp0[i]); end
        end
        while (cyc < 2920) begin
            tick();
            if (prev === 1'b1 && hsync === 1'b0) begin
                if (fall0 < 0) fall0 = cyc;
                else if (fall1 < 0) fall1 = cyc;
            end
            prev = hsync;
        end
        checks++; if (fall0 != 1315) begin errors++; $display("FAIL stall_hsync_fall: got %0d expected %0d", fall0, 1315); end
        checks++; if (fall1 - fall0 != 1600) begin errors++; $display("FAIL stall_line_period: got %0d expected %0d", fall1 - fall0, 1600); end
    endtask

    initial begin
        for (int i = 0; i < 2400; i++) vram[i] = 8'h00;
        for (int i = 0; i < 2048; i++) font[i] = 8'h00;
        vram[0]   = 8'h41;
        vram[1]   = 8'h81;
        vram[159] = 8'h02;
        font[11'h410] = 8'hC3;
        font[11'h411] = 8'h18;
        font[11'h010] = 8'h5A;
        font[11'h020] = 8'h01;

        test_reset();
        test_render();
        test_address();
        test_vblank_flag();
        test_timing();
        test_stall();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
